// File: rtl/dpctl_pkg.sv
// Shared types and helpers for the datapath step controller: mode encoding,
// event priority and counter-width helpers.
package dpctl_pkg;

  typedef enum logic [1:0] {
    ST_HALT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STEP  = 2'd2,
    ST_BREAK = 2'd3
  } dp_state_e;

  // Larger encoding wins when several button events land in the same cycle.
  typedef enum logic [1:0] {
    EV_NONE     = 2'd0,
    EV_RUN_RISE = 2'd1,
    EV_STEP     = 2'd2,
    EV_HALT     = 2'd3
  } dp_event_e;

  localparam int DEF_DEBOUNCE_CYCLES = 250000;
  localparam int DEF_RUN_DIV         = 10000000;
  localparam int DEF_CNT_W           = 13;

  function automatic dp_event_e pick_event(input logic halt_evt,
                                           input logic step_evt,
                                           input logic run_rise);
    if (halt_evt)      return EV_HALT;
    else if (step_evt) return EV_STEP;
    else if (run_rise) return EV_RUN_RISE;
    else               return EV_NONE;
  endfunction

  // Bits needed to hold 0..n-1.
  function automatic int ctr_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchronizer plus stable-count debouncer for one raw board input;
// emits the debounced level and single-cycle rise/fall pulses.
module button_debouncer
  import dpctl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int              CW      = ctr_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned and infers a latch.
    sync_d  = {sync_q[0], raw};
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (sync_q[1] == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d   = '0;
      level_d = sync_q[1];
      rise_d  = sync_q[1];
      fall_d  = ~sync_q[1];
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/datapath_step_controller.sv
// Issues the single-cycle datapath clock-enable in HALT/RUN/STEP/BREAK modes and
// counts issued cycles. Define STEP_BP_EN to enable the PC breakpoint and BREAK mode.
module datapath_step_controller
  import dpctl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int RUN_DIV         = DEF_RUN_DIV,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_sw,
  input  logic             step_btn,
  input  logic             halt_btn,
  input  logic [31:0]      pc_in,
  input  logic [31:0]      bp_addr,
  input  logic             bp_valid,
  output logic             dp_ce,
  output logic [1:0]       state,
  output logic             bp_hit,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int            PW      = ctr_width(RUN_DIV);
  localparam logic [PW-1:0] PRE_MAX = PW'(RUN_DIV - 1);

  logic run_rise, run_fall, step_evt, halt_evt;
  logic run_level_unused, step_level_unused, step_fall_unused;
  logic halt_level_unused, halt_fall_unused;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run_db (
    .clk(clk), .rst(rst), .raw(run_sw),
    .level(run_level_unused), .rise(run_rise), .fall(run_fall)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_db (
    .clk(clk), .rst(rst), .raw(step_btn),
    .level(step_level_unused), .rise(step_evt), .fall(step_fall_unused)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_halt_db (
    .clk(clk), .rst(rst), .raw(halt_btn),
    .level(halt_level_unused), .rise(halt_evt), .fall(halt_fall_unused)
  );

  dp_state_e        state_q, state_d;
  logic [PW-1:0]    prescaler_q, prescaler_d;
  logic             dp_ce_q, dp_ce_d;
  logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
  logic             skip_bp_q, skip_bp_d;
  logic             bp_match;
  dp_event_e        evt;

`ifdef STEP_BP_EN
  assign bp_match = bp_valid && (pc_in == bp_addr) && !skip_bp_q;
  assign bp_hit   = (state_q == ST_BREAK);
`else
  logic bp_unused;
  assign bp_unused = ^{pc_in, bp_addr, bp_valid, skip_bp_q};
  assign bp_match  = 1'b0;
  assign bp_hit    = 1'b0;
`endif

  assign evt = pick_event(halt_evt, step_evt, run_rise);

  always_comb begin
    state_d       = state_q;
    prescaler_d   = prescaler_q;
    dp_ce_d       = 1'b0;
    cycle_count_d = cycle_count_q;
    skip_bp_d     = skip_bp_q;
    unique case (state_q)
      ST_HALT: begin
        if (evt == EV_STEP) begin
          state_d = ST_STEP;
        end else if (evt == EV_RUN_RISE) begin
          state_d     = ST_RUN;
          prescaler_d = '0;
        end
      end
      // Single issue; anything arriving in this cycle is intentionally dropped.
      ST_STEP: begin
        dp_ce_d       = 1'b1;
        cycle_count_d = cycle_count_q + 1'b1;
        skip_bp_d     = 1'b0;
        state_d       = ST_HALT;
      end
      ST_RUN: begin
        if (halt_evt || run_fall) begin
          state_d     = ST_HALT;
          prescaler_d = '0;
        end else if (prescaler_q == PRE_MAX) begin
          prescaler_d = '0;
          if (bp_match) begin
            state_d = ST_BREAK;
          end else begin
            dp_ce_d       = 1'b1;
            cycle_count_d = cycle_count_q + 1'b1;
            skip_bp_d     = 1'b0;
          end
        end else begin
          prescaler_d = prescaler_q + 1'b1;
        end
      end
      // Leaving sets skip_bp so the breakpoint instruction can execute once.
      ST_BREAK: begin
        if (evt == EV_HALT) begin
          state_d   = ST_HALT;
          skip_bp_d = 1'b1;
        end else if (evt == EV_STEP) begin
          state_d   = ST_STEP;
          skip_bp_d = 1'b1;
        end else if (evt == EV_RUN_RISE) begin
          state_d     = ST_RUN;
          prescaler_d = '0;
          skip_bp_d   = 1'b1;
        end
      end
      default: state_d = ST_HALT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_HALT;
      prescaler_q   <= '0;
      dp_ce_q       <= 1'b0;
      cycle_count_q <= '0;
      skip_bp_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      prescaler_q   <= prescaler_d;
      dp_ce_q       <= dp_ce_d;
      cycle_count_q <= cycle_count_d;
      skip_bp_q     <= skip_bp_d;
    end
  end

  assign dp_ce       = dp_ce_q;
  assign state       = state_q;
  assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_datapath_step_controller.sv
// Directed bench for datapath_step_controller with short debounce and run divider.
module tb_datapath_step_controller;

  localparam int DEBOUNCE_CYCLES = 4;
  localparam int RUN_DIV         = 8;
  localparam int CNT_W           = 13;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             run_sw = 1'b0;
  logic             step_btn = 1'b0;
  logic             halt_btn = 1'b0;
  logic [31:0]      pc_in = 32'h0;
  logic [31:0]      bp_addr = 32'h0;
  logic             bp_valid = 1'b0;
  logic             dp_ce;
  logic [1:0]       state;
  logic             bp_hit;
  logic [CNT_W-1:0] cycle_count;

  datapath_step_controller #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .RUN_DIV(RUN_DIV),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .run_sw(run_sw), .step_btn(step_btn),
    .halt_btn(halt_btn), .pc_in(pc_in), .bp_addr(bp_addr), .bp_valid(bp_valid),
    .dp_ce(dp_ce), .state(state), .bp_hit(bp_hit), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   ce_seen = 0;
  int   step_cycles = 0;
  logic ce_prev = 1'b0;
  logic ce_double = 1'b0;

  // Observes dp_ce pulses, back-to-back pulses and cycles spent in STEP.
  always @(negedge clk) begin
    if (dp_ce) ce_seen <= ce_seen + 1;
    if (dp_ce && ce_prev) ce_double <= 1'b1;
    ce_prev <= dp_ce;
    if (state == 2'd2) step_cycles <= step_cycles + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_state(input logic [1:0] s, input int max_cycles, input string tag);
    int i = 0;
    while (state !== s && i < max_cycles) begin
      @(negedge clk);
      i++;
    end
    check(tag, 32'(state), 32'(s));
  endtask

  int base_ce;
  int base_step;
  int lat;

  initial begin
    // Reset held with run switch already on.
    run_sw = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_state", 32'(state), 32'd0);
    check("rst_dp_ce", 32'(dp_ce), 32'd0);
    check("rst_count", 32'(cycle_count), 32'd0);
    check("rst_bp_hit", 32'(bp_hit), 32'd0);

    // 2 sync + 4 debounce + 1 registered event = RUN on the 7th edge.
    rst = 1'b1;
    lat = 0;
    while (state !== 2'd1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("run_entry_latency", 32'(lat), 32'd7);

    // Switch off before the first issue point: no pulse.
    run_sw = 1'b0;
    wait_state(2'd0, 20, "run_fall_halt");
    repeat (2) @(negedge clk);
    check("run_fall_count", 32'(cycle_count), 32'd0);
    check("run_fall_ce", 32'(ce_seen), 32'd0);

    // Bouncy step press.
    base_ce   = ce_seen;
    base_step = step_cycles;
    step_btn = 1'b1; @(negedge clk);
    step_btn = 1'b0; @(negedge clk);
    step_btn = 1'b1; repeat (10) @(negedge clk);
    step_btn = 1'b0; repeat (10) @(negedge clk);
    check("step_ce_pulses", 32'(ce_seen - base_ce), 32'd1);
    check("step_cycles", 32'(step_cycles - base_step), 32'd1);
    check("step_count", 32'(cycle_count), 32'd1);
    check("step_state", 32'(state), 32'd0);

    // Free run: 81 edges after entry cover issues at +8..+80.
    run_sw = 1'b1;
    wait_state(2'd1, 20, "run_entry");
    base_ce = ce_seen;
    repeat (81) @(negedge clk);
    check("run_ce_pulses", 32'(ce_seen - base_ce), 32'd10);
    check("run_count", 32'(cycle_count), 32'd11);

    // Halt event lands exactly on the next issue point and must cancel it.
    base_ce = ce_seen;
    halt_btn = 1'b1;
    wait_state(2'd0, 20, "halt_in_run");
    check("halt_prescaler", 32'(dut.prescaler_q), 32'd0);
    repeat (30) @(negedge clk);
    check("halt_no_ce", 32'(ce_seen - base_ce), 32'd0);
    check("halt_count", 32'(cycle_count), 32'd11);
    halt_btn = 1'b0;
    repeat (10) @(negedge clk);

    // Halt and step rise together while running.
    run_sw = 1'b0; repeat (10) @(negedge clk);
    run_sw = 1'b1;
    wait_state(2'd1, 20, "run_entry_sim");
    base_ce   = ce_seen;
    base_step = step_cycles;
    halt_btn = 1'b1;
    step_btn = 1'b1;
    repeat (15) @(negedge clk);
    check("sim_no_step", 32'(step_cycles - base_step), 32'd0);
    check("sim_state", 32'(state), 32'd0);
    check("sim_no_ce", 32'(ce_seen - base_ce), 32'd0);
    check("sim_count", 32'(cycle_count), 32'd11);
    halt_btn = 1'b0;
    step_btn = 1'b0;
    repeat (10) @(negedge clk);

    // Breakpoint at the first issue point of a fresh run.
    pc_in    = 32'h0000_0010;
    bp_addr  = 32'h0000_0010;
    bp_valid = 1'b1;
    run_sw = 1'b0; repeat (10) @(negedge clk);
    run_sw = 1'b1;
    wait_state(2'd1, 20, "run_entry_bp");
    base_ce = ce_seen;
`ifdef STEP_BP_EN
    wait_state(2'd3, 20, "bp_break");
    repeat (2) @(negedge clk);
    check("bp_no_ce", 32'(ce_seen - base_ce), 32'd0);
    check("bp_hit_high", 32'(bp_hit), 32'd1);
    check("bp_count", 32'(cycle_count), 32'd11);
    base_ce = ce_seen;
    step_btn = 1'b1;
    wait_state(2'd0, 20, "bp_step_halt");
    repeat (2) @(negedge clk);
    step_btn = 1'b0;
    check("bp_step_ce", 32'(ce_seen - base_ce), 32'd1);
    check("bp_hit_low", 32'(bp_hit), 32'd0);
    check("bp_step_count", 32'(cycle_count), 32'd12);
    pc_in = 32'h0;
    run_sw = 1'b0; repeat (10) @(negedge clk);
    run_sw = 1'b1;
    wait_state(2'd1, 20, "run_entry_wrap");
`else
    repeat (10) @(negedge clk);
    check("nobp_ce", 32'(ce_seen - base_ce), 32'd1);
    check("nobp_bp_hit", 32'(bp_hit), 32'd0);
    check("nobp_state", 32'(state), 32'd1);
    check("nobp_count", 32'(cycle_count), 32'd12);
    pc_in = 32'h0;
`endif

    // Keep running until the counter reaches its top, then one more issue wraps it.
    for (int i = 0; i < 70000; i++) begin
      @(negedge clk);
      if (cycle_count == 13'd8191) break;
    end
    check("reach_8191", 32'(cycle_count), 32'd8191);
    repeat (8) @(negedge clk);
    check("wrap_ce", 32'(dp_ce), 32'd1);
    check("wrap_count", 32'(cycle_count), 32'd0);
    run_sw = 1'b0;
    repeat (12) @(negedge clk);
    check("ce_never_double", 32'(ce_double), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
